fetch_mem_unit: RTL

- Owns the program counter, the instruction register and the single memory port of the 16-bit RISC CPU.
- Sits directly downstream of the control unit and consumes its control word: pc_ld, pc_inc, pc_sel, ir_ld, adr_sel, s_sel and mw_en.
- Produces IR for the control unit's decode and ld_data for the register-file write mux.
- Sequences variable-latency memory transactions and drives a stall output that freezes the control-unit sequencer (clock enable) while a transaction is outstanding.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/pc_unit.sv | 59 +++++
 rtl/fetch_mem_unit.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 16-bit RISC CPU datapath blocks.
//   AW_DEF / DW_DEF     : default address and data widths
//   RESET_PC_DEF        : program counter value after reset
//   TIMEOUT_DEF         : wait cycles without mem_ack before a bus error
//   mem_state_e         : memory sequencer state encoding
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int          AW_DEF       = 16;
    localparam int          DW_DEF       = 16;
    localparam logic [15:0] RESET_PC_DEF = 16'h0000;
    localparam int          TIMEOUT_DEF  = 255;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        ERR     = 2'd3
    } mem_state_e;

endpackage

// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit
// Program counter register with incrementer, jump-target mux and 9-bit
// sign extension of the instruction's branch offset.
//   clk, reset  : clock, asynchronous active-low reset
//   upd_en      : apply the selected PC update at this edge
//   pc_ld       : load jump target (wins over pc_inc)
//   pc_inc      : increment PC
//   pc_sel      : 1 = absolute target, 0 = PC + sext(offset)
//   target_abs  : absolute jump target
//   offset      : ir[8:0] branch offset
//   pc          : current program counter
// ---------------------------------------------------------------------------
module pc_unit #(
    parameter int            AW       = 16,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          upd_en,
    input  logic          pc_ld,
    input  logic          pc_inc,
    input  logic          pc_sel,
    input  logic [AW-1:0] target_abs,
    input  logic [8:0]    offset,
    output logic [AW-1:0] pc
);

    logic [AW-1:0] pc_q;
    logic [AW-1:0] pc_d;
    logic [AW-1:0] offset_sext;
    logic [AW-1:0] rel_target;

    // Next-PC selection; all arithmetic wraps modulo 2^AW naturally.
    always_comb begin
        offset_sext = {{(AW-9){offset[8]}}, offset};
        rel_target  = pc_q + offset_sext;
        pc_d        = pc_q;
        if (upd_en) begin
            if (pc_ld) begin
                pc_d = pc_sel ? target_abs : rel_target;
            end else if (pc_inc) begin
                pc_d = pc_q + AW'(1);
            end
        end
    end

    // PC register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_mem_unit.sv
// ---------------------------------------------------------------------------
// fetch_mem_unit
// Owns the PC, the instruction register and the single memory port. Turns
// the control unit's fetch/load/store requests into variable-latency memory
// transactions and stalls the control unit while one is outstanding.
//   clk, reset            : clock, asynchronous active-low reset
//   pc_ld/pc_inc/pc_sel   : PC update controls
//   ir_ld/s_sel/mw_en     : fetch / data read / data write requests
//   adr_sel               : memory address 1 = addr_reg, 0 = PC
//   alu_out/addr_reg/st_data : jump target, data address, store data
//   ir/pc/ld_data         : instruction register, PC, last loaded word
//   stall                 : hold the control-unit sequencer
//   bus_err               : sticky memory timeout flag
//   mem_*                 : memory port (registered request side)
// ---------------------------------------------------------------------------
module fetch_mem_unit
    import cpu_pkg::*;
#(
    parameter int            AW       = AW_DEF,
    parameter int            DW       = DW_DEF,
    parameter logic [AW-1:0] RESET_PC = AW'(RESET_PC_DEF),
    parameter int            TIMEOUT  = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pc_ld,
    input  logic          pc_inc,
    input  logic          pc_sel,
    input  logic          ir_ld,
    input  logic          adr_sel,
    input  logic          s_sel,
    input  logic          mw_en,
    input  logic [DW-1:0] alu_out,
    input  logic [DW-1:0] addr_reg,
    input  logic [DW-1:0] st_data,
    output logic [DW-1:0] ir,
    output logic [AW-1:0] pc,
    output logic [DW-1:0] ld_data,
    output logic          stall,
    output logic          bus_err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack
);

    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    mem_state_e    state_q, state_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] ir_q, ir_d;
    logic [DW-1:0] ld_data_q, ld_data_d;
    logic          bus_err_q, bus_err_d;
    logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;

    // Request kind and PC update latched at issue, since inputs are only
    // sampled in IDLE but the PC moves at the completion edge.
    logic          fetch_q, fetch_d;
    logic          load_q, load_d;
    logic          pend_ld_q, pend_ld_d;
    logic          pend_inc_q, pend_inc_d;
    logic          pend_sel_q, pend_sel_d;
    logic [AW-1:0] pend_target_q, pend_target_d;

    logic          op_req;
    logic          stall_c;
    logic          pc_upd_en;
    logic          pc_ld_c;
    logic          pc_inc_c;
    logic          pc_sel_c;
    logic [AW-1:0] pc_target_c;

    // Sequencer next-state, datapath capture and PC-update steering.
    always_comb begin
        op_req        = ir_ld | s_sel | mw_en;
        state_d       = state_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        ir_d          = ir_q;
        ld_data_d     = ld_data_q;
        bus_err_d     = bus_err_q;
        tmo_cnt_d     = tmo_cnt_q;
        fetch_d       = fetch_q;
        load_d        = load_q;
        pend_ld_d     = pend_ld_q;
        pend_inc_d    = pend_inc_q;
        pend_sel_d    = pend_sel_q;
        pend_target_d = pend_target_q;
        stall_c       = 1'b0;
        pc_upd_en     = 1'b0;
        pc_ld_c       = pc_ld;
        pc_inc_c      = pc_inc;
        pc_sel_c      = pc_sel;
        pc_target_c   = alu_out[AW-1:0];

        unique case (state_q)
            IDLE: begin
                if (op_req) begin
                    stall_c       = 1'b1;
                    mem_req_d     = 1'b1;
                    mem_we_d      = mw_en;
                    mem_addr_d    = adr_sel ? addr_reg[AW-1:0] : pc;
                    mem_wdata_d   = st_data;
                    // A write wins over any simultaneous read request.
                    fetch_d       = ir_ld & ~mw_en;
                    load_d        = s_sel & ~mw_en;
                    pend_ld_d     = pc_ld;
                    pend_inc_d    = pc_inc;
                    pend_sel_d    = pc_sel;
                    pend_target_d = alu_out[AW-1:0];
                    tmo_cnt_d     = '0;
                    state_d       = mw_en ? WR_WAIT : RD_WAIT;
                end else begin
                    pc_upd_en = 1'b1;
                end
            end
            RD_WAIT, WR_WAIT: begin
                pc_ld_c     = pend_ld_q;
                pc_inc_c    = pend_inc_q;
                pc_sel_c    = pend_sel_q;
                pc_target_c = pend_target_q;
                if (mem_ack) begin
                    pc_upd_en = 1'b1;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (fetch_q) begin
                        ir_d = mem_rdata;
                    end
                    if (load_q) begin
                        ld_data_d = mem_rdata;
                    end
                    state_d = IDLE;
                end else begin
                    stall_c = 1'b1;
                    if (tmo_cnt_q == TMO_LAST) begin
                        mem_req_d = 1'b0;
                        mem_we_d  = 1'b0;
                        bus_err_d = 1'b1;
                        state_d   = ERR;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + CW'(1);
                    end
                end
            end
            ERR: begin
                stall_c = 1'b1;
            end
        endcase
    end

    // Single register bank for the sequencer and its registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            ir_q          <= '0;
            ld_data_q     <= '0;
            bus_err_q     <= 1'b0;
            tmo_cnt_q     <= '0;
            fetch_q       <= 1'b0;
            load_q        <= 1'b0;
            pend_ld_q     <= 1'b0;
            pend_inc_q    <= 1'b0;
            pend_sel_q    <= 1'b0;
            pend_target_q <= '0;
        end else begin
            state_q       <= state_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            ir_q          <= ir_d;
            ld_data_q     <= ld_data_d;
            bus_err_q     <= bus_err_d;
            tmo_cnt_q     <= tmo_cnt_d;
            fetch_q       <= fetch_d;
            load_q        <= load_d;
            pend_ld_q     <= pend_ld_d;
            pend_inc_q    <= pend_inc_d;
            pend_sel_q    <= pend_sel_d;
            pend_target_q <= pend_target_d;
        end
    end

    pc_unit #(
        .AW       (AW),
        .RESET_PC (RESET_PC)
    ) u_pc_unit (
        .clk        (clk),
        .reset      (reset),
        .upd_en     (pc_upd_en),
        .pc_ld      (pc_ld_c),
        .pc_inc     (pc_inc_c),
        .pc_sel     (pc_sel_c),
        .target_abs (pc_target_c),
        .offset     (ir_q[8:0]),
        .pc         (pc)
    );

    assign ir        = ir_q;
    assign ld_data   = ld_data_q;
    assign stall     = stall_c;
    assign bus_err   = bus_err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
